vram_arb: RTL and testbench

Parametrised multi-channel VRAM for the HuC6270 VDC: a single synchronous word-addressed memory shared by NCH requesters (CPU port, background fetch, sprite fetch, VRAM-DMA) through a request/grant arbiter. It performs one access per clock, returns read data one cycle after grant, and runs a hardware clear sweep after reset so software sees all-zero VRAM without a reset-time array loop. It sits between the VDC internal masters and the VRAM storage.

---
 rtl/vram_arb_if.sv | 28 ++
 rtl/vram_arb.sv | 154 +++++++++++++++
 tb/tb_vram_arb.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/vram_arb_if.sv
// Request/grant bus between the VDC internal masters and vram_arb.
// Per-channel fields are packed side by side, channel i at [i*W +: W].
interface vram_arb_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 15,
  parameter int NCH    = 4
) ();

  logic [NCH-1:0]        req;
  logic [NCH-1:0]        we;
  logic [NCH*ADDR_W-1:0] addr;
  logic [NCH*DATA_W-1:0] wdata;
  logic [NCH-1:0]        gnt;
  logic [NCH-1:0]        rvalid;
  logic [DATA_W-1:0]     rdata;
  logic                  busy;

  modport master (
    output req, we, addr, wdata,
    input  gnt, rvalid, rdata, busy
  );

  modport slave (
    input  req, we, addr, wdata,
    output gnt, rvalid, rdata, busy
  );

endinterface

// File: rtl/vram_arb.sv
// vram_arb: NCH-channel request/grant arbiter in front of one word-addressed VRAM.
// Defining VRAM_CLEAR_EN adds a post-reset sweep that zeroes every word before grants start.
module vram_arb #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 15,
  parameter int NCH    = 4,
  parameter int ARB_RR = 0
) (
  input logic       clock,
  input logic       reset_N,
  vram_arb_if.slave bus
);

  localparam int               IDX_W    = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int               DEPTH    = 1 << ADDR_W;
  localparam logic [IDX_W:0]   NCH_L    = (IDX_W+1)'(NCH);
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NCH - 1);

  logic [DATA_W-1:0] mem_r [DEPTH];

  logic [NCH-1:0]    gnt_s;
  logic [IDX_W-1:0]  gidx_s;
  logic              gnt_any_s;
  logic [IDX_W-1:0]  last_r;
  logic              run_s;
  logic              clearing_s;

  logic [ADDR_W-1:0] sel_addr_s;
  logic [DATA_W-1:0] sel_wdata_s;
  logic              sel_we_s;
  logic              rd_en_s;

  logic              mem_we_s;
  logic [ADDR_W-1:0] mem_addr_s;
  logic [DATA_W-1:0] mem_wdata_s;

  logic [NCH-1:0]    rvalid_r;
  logic [DATA_W-1:0] rdata_r;

`ifdef VRAM_CLEAR_EN
  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  state_t            state_r;
  state_t            state_nx_s;
  logic [ADDR_W-1:0] clr_addr_r;

  // state register and clear-sweep address counter
  always_ff @(posedge clock or negedge reset_N) begin
    if (!reset_N) begin
      state_r    <= ST_CLEAR;
      clr_addr_r <= '0;
    end else begin
      state_r    <= state_nx_s;
      clr_addr_r <= (state_r == ST_CLEAR) ? clr_addr_r + ADDR_W'(1) : clr_addr_r;
    end
  end

  // leave CLEAR once the last word has been written
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_CLEAR: begin
        if (clr_addr_r == {ADDR_W{1'b1}}) begin
          state_nx_s = ST_RUN;
        end else begin
          state_nx_s = ST_CLEAR;
        end
      end
      ST_RUN:  state_nx_s = ST_RUN;
      default: state_nx_s = ST_CLEAR;
    endcase
  end

  assign run_s       = (state_r == ST_RUN);
  assign clearing_s  = (state_r == ST_CLEAR);
  assign mem_addr_s  = clearing_s ? clr_addr_r : sel_addr_s;
`else
  assign run_s       = 1'b1;
  assign clearing_s  = 1'b0;
  assign mem_addr_s  = sel_addr_s;
`endif

  // grant selection: fixed priority from channel 0, or round-robin starting after last_r
  always_comb begin
    logic           hit;
    logic [IDX_W:0] cand;
    hit       = 1'b0;
    cand      = '0;
    gidx_s    = '0;
    gnt_any_s = 1'b0;
    if (run_s) begin
      if (ARB_RR != 0) begin
        for (int k = 1; k <= NCH; k++) begin
          cand = {1'b0, last_r} + (IDX_W+1)'(k);
          if (cand >= NCH_L) begin
            cand = cand - NCH_L;
          end else begin
            cand = cand;
          end
          hit       = !gnt_any_s && bus.req[cand[IDX_W-1:0]];
          gidx_s    = hit ? cand[IDX_W-1:0] : gidx_s;
          gnt_any_s = gnt_any_s | hit;
        end
      end else begin
        for (int i = 0; i < NCH; i++) begin
          hit       = !gnt_any_s && bus.req[IDX_W'(i)];
          gidx_s    = hit ? IDX_W'(i) : gidx_s;
          gnt_any_s = gnt_any_s | hit;
        end
      end
    end else begin
      gnt_any_s = 1'b0;
    end
    gnt_s = gnt_any_s ? (NCH'(1) << gidx_s) : '0;
  end

  assign sel_addr_s  = bus.addr[int'(gidx_s)*ADDR_W +: ADDR_W];
  assign sel_wdata_s = bus.wdata[int'(gidx_s)*DATA_W +: DATA_W];
  assign sel_we_s    = bus.we[gidx_s];
  assign rd_en_s     = gnt_any_s & ~sel_we_s;

  // the sweep owns the write port while clearing; no grants exist then
  assign mem_we_s    = clearing_s | (gnt_any_s & sel_we_s);
  assign mem_wdata_s = clearing_s ? '0 : sel_wdata_s;

  // storage array write port
  always_ff @(posedge clock) begin
    if (mem_we_s) begin
      mem_r[mem_addr_s] <= mem_wdata_s;
    end
  end

  // registered read data, one-hot read valid and round-robin pointer
  always_ff @(posedge clock or negedge reset_N) begin
    if (!reset_N) begin
      rdata_r  <= '0;
      rvalid_r <= '0;
      last_r   <= LAST_RST;
    end else begin
      rdata_r  <= rd_en_s ? mem_r[sel_addr_s] : rdata_r;
      rvalid_r <= rd_en_s ? gnt_s : '0;
      last_r   <= ((ARB_RR != 0) && gnt_any_s) ? gidx_s : last_r;
    end
  end

  assign bus.gnt    = gnt_s;
  assign bus.rvalid = rvalid_r;
  assign bus.rdata  = rdata_r;
  assign bus.busy   = ~run_s;

endmodule

// File: tb/tb_vram_arb.sv
// Scoreboard bench for vram_arb: dut A fixed priority, dut B round-robin, ADDR_W=6, NCH=4.
// Expected grants and read responses are queued at issue time and popped by a negedge monitor.
module tb_vram_arb;

`ifdef VRAM_CLEAR_EN
  localparam int CLR_N = 64;
`else
  localparam int CLR_N = 0;
`endif

  logic clock;
  logic reset_N;

  logic [3:0]  a_req, a_we, b_req, b_we;
  logic [23:0] a_addr, b_addr;
  logic [63:0] a_wdata, b_wdata;

  logic [3:0]  qg_a[$], qg_b[$];
  logic [19:0] qr_a[$], qr_b[$];

  int n_chk  = 0;
  int n_pass = 0;

  vram_arb_if #(.DATA_W(16), .ADDR_W(6), .NCH(4)) ifa ();
  vram_arb_if #(.DATA_W(16), .ADDR_W(6), .NCH(4)) ifb ();

  assign ifa.req = a_req;  assign ifa.we = a_we;  assign ifa.addr = a_addr;  assign ifa.wdata = a_wdata;
  assign ifb.req = b_req;  assign ifb.we = b_we;  assign ifb.addr = b_addr;  assign ifb.wdata = b_wdata;

  vram_arb #(.DATA_W(16), .ADDR_W(6), .NCH(4), .ARB_RR(0)) u_a (
    .clock(clock), .reset_N(reset_N), .bus(ifa)
  );
  vram_arb #(.DATA_W(16), .ADDR_W(6), .NCH(4), .ARB_RR(1)) u_b (
    .clock(clock), .reset_N(reset_N), .bus(ifb)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // d: 0 = dut A, 1 = dut B, 2 = both
  task automatic put(input int d, input int ch, input logic w, input logic [5:0] ad, input logic [15:0] dt);
    if (d != 1) begin
      a_req[ch] = 1'b1; a_we[ch] = w; a_addr[ch*6 +: 6] = ad; a_wdata[ch*16 +: 16] = dt;
    end
    if (d != 0) begin
      b_req[ch] = 1'b1; b_we[ch] = w; b_addr[ch*6 +: 6] = ad; b_wdata[ch*16 +: 16] = dt;
    end
  endtask

  task automatic drop(input int d, input int ch);
    if (d != 1) a_req[ch] = 1'b0;
    if (d != 0) b_req[ch] = 1'b0;
  endtask

  task automatic idle(input int d);
    if (d != 1) a_req = 4'b0000;
    if (d != 0) b_req = 4'b0000;
  endtask

  task automatic eg(input int d, input logic [3:0] g);
    if (d != 1) qg_a.push_back(g);
    if (d != 0) qg_b.push_back(g);
  endtask

  task automatic er(input int d, input logic [3:0] v, input logic [15:0] dt);
    if (d != 1) qr_a.push_back({v, dt});
    if (d != 0) qr_b.push_back({v, dt});
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // called just after reset_N rises; returns at the negedge of the first RUN cycle
  task automatic measure_clear(input string nm);
    int na;
    int nb;
    na = 0;
    nb = 0;
    @(negedge clock);
    while ((ifa.busy === 1'b1 || ifb.busy === 1'b1) && (na + nb) < 400) begin
      if (ifa.busy === 1'b1) na++;
      if (ifb.busy === 1'b1) nb++;
      chk({nm, "_gnt_during_busy"}, {28'd0, ifa.gnt}, 32'd0);
      @(negedge clock);
    end
    chk({nm, "_busy_cycles_A"}, na, CLR_N);
    chk({nm, "_busy_cycles_B"}, nb, CLR_N);
  endtask

  // scoreboard monitor
  always @(negedge clock) begin
    if (reset_N === 1'b1) begin
      if (ifa.gnt !== 4'b0000) begin
        if (qg_a.size() == 0) chk("A_gnt_unexpected", {28'd0, ifa.gnt}, 32'd0);
        else chk("A_gnt", {28'd0, ifa.gnt}, {28'd0, qg_a.pop_front()});
      end
      if (ifb.gnt !== 4'b0000) begin
        if (qg_b.size() == 0) chk("B_gnt_unexpected", {28'd0, ifb.gnt}, 32'd0);
        else chk("B_gnt", {28'd0, ifb.gnt}, {28'd0, qg_b.pop_front()});
      end
      if (ifa.rvalid !== 4'b0000) begin
        if (qr_a.size() == 0) chk("A_read_unexpected", {12'd0, ifa.rvalid, ifa.rdata}, 32'd0);
        else chk("A_read", {12'd0, ifa.rvalid, ifa.rdata}, {12'd0, qr_a.pop_front()});
      end
      if (ifb.rvalid !== 4'b0000) begin
        if (qr_b.size() == 0) chk("B_read_unexpected", {12'd0, ifb.rvalid, ifb.rdata}, 32'd0);
        else chk("B_read", {12'd0, ifb.rvalid, ifb.rdata}, {12'd0, qr_b.pop_front()});
      end
    end
  end

  initial begin
    reset_N = 1'b0;
    a_req = '0; a_we = '0; a_addr = '0; a_wdata = '0;
    b_req = '0; b_we = '0; b_addr = '0; b_wdata = '0;

    @(negedge clock);
    chk("rst_gnt_A",    {28'd0, ifa.gnt},    32'd0);
    chk("rst_rvalid_A", {28'd0, ifa.rvalid}, 32'd0);
    chk("rst_rdata_A",  {16'd0, ifa.rdata},  32'd0);
    chk("rst_busy_A",   {31'd0, ifa.busy},   (CLR_N > 0) ? 32'd1 : 32'd0);
    chk("rst_rvalid_B", {28'd0, ifb.rvalid}, 32'd0);
    chk("rst_busy_B",   {31'd0, ifb.busy},   (CLR_N > 0) ? 32'd1 : 32'd0);

    // release with a write on A channel 3 already pending: granted as soon as busy falls
    tick();
    reset_N = 1'b1;
    put(0, 3, 1'b1, 6'h05, 16'hABCD);
    eg(0, 4'b1000);
    measure_clear("clear1");
    tick();
    idle(2);

    // A: write then read-after-write; B: round-robin contention with four writers
    put(0, 1, 1'b1, 6'h10, 16'h1234);                  eg(0, 4'b0010);
    for (int k = 0; k < 4; k++) put(1, k, 1'b1, 6'(32 + k), 16'(16'hB000 + k));
    eg(1, 4'b0001);
    tick();
    idle(0);
    put(0, 2, 1'b0, 6'h10, 16'h0000);  eg(0, 4'b0100);  er(0, 4'b0100, 16'h1234);
    eg(1, 4'b0010);
    tick();
    // A: fixed-priority contention with four readers
    idle(0);
    put(0, 0, 1'b0, 6'h10, 16'h0000);
    put(0, 1, 1'b0, 6'h05, 16'h0000);
    put(0, 2, 1'b0, 6'h10, 16'h0000);
    put(0, 3, 1'b0, 6'h05, 16'h0000);
    eg(0, 4'b0001);  er(0, 4'b0001, 16'h1234);  eg(1, 4'b0100);
    tick();
    drop(0, 0);
    eg(0, 4'b0010);  er(0, 4'b0010, 16'hABCD);  eg(1, 4'b1000);
    tick();
    drop(0, 1);
    put(0, 0, 1'b0, 6'h05, 16'h0000);
    eg(0, 4'b0001);  er(0, 4'b0001, 16'hABCD);  eg(1, 4'b0001);
    tick();
    drop(0, 0);
    eg(0, 4'b0100);  er(0, 4'b0100, 16'h1234);  eg(1, 4'b0010);
    tick();
    drop(0, 2);
    eg(0, 4'b1000);  er(0, 4'b1000, 16'hABCD);
    // B: last=1, so channel 0 is reached after 2 and 3
    idle(1);
    put(1, 0, 1'b0, 6'h20, 16'h0000);  eg(1, 4'b0001);  er(1, 4'b0001, 16'hB000);
    tick();
    idle(2);
    put(1, 1, 1'b0, 6'h21, 16'h0000);
    put(1, 3, 1'b0, 6'h23, 16'h0000);
    eg(1, 4'b0010);  er(1, 4'b0010, 16'hB001);
    tick();
    drop(1, 1);
    put(1, 2, 1'b0, 6'h22, 16'h0000);
    eg(1, 4'b0100);  er(1, 4'b0100, 16'hB002);
    tick();
    drop(1, 2);
    eg(1, 4'b1000);  er(1, 4'b1000, 16'hB003);
    tick();
    idle(2);
    tick();
    @(negedge clock);
    chk("hold_rdata_A",  {16'd0, ifa.rdata},  32'h0000ABCD);
    chk("hold_rvalid_A", {28'd0, ifa.rvalid}, 32'd0);
    chk("hold_rdata_B",  {16'd0, ifb.rdata},  32'h0000B003);

    // reset while a granted read is in flight: its data must never appear
    tick();
    put(0, 1, 1'b0, 6'h05, 16'h0000);
    eg(0, 4'b0010);
    @(negedge clock);
    #1;
    reset_N = 1'b0;
    idle(2);
    #1;
    chk("midread_rvalid_A", {28'd0, ifa.rvalid}, 32'd0);
    chk("midread_rdata_A",  {16'd0, ifa.rdata},  32'd0);
    chk("midread_rdata_B",  {16'd0, ifb.rdata},  32'd0);
    chk("midread_busy_A",   {31'd0, ifa.busy},   (CLR_N > 0) ? 32'd1 : 32'd0);
    @(negedge clock);
    chk("midread_rvalid_A2", {28'd0, ifa.rvalid}, 32'd0);
    tick();
    reset_N = 1'b1;
    measure_clear("clear2");
    tick();

`ifdef VRAM_CLEAR_EN
    // fill everything with 0xFFFF, confirm one word, then interrupt the next sweep at clr_addr=20
    for (int i = 0; i < 64; i++) begin
      idle(2);
      put(2, 0, 1'b1, 6'(i), 16'hFFFF);
      eg(2, 4'b0001);
      tick();
    end
    idle(2);
    put(2, 3, 1'b0, 6'h3F, 16'h0000);  eg(2, 4'b1000);  er(2, 4'b1000, 16'hFFFF);
    tick();
    idle(2);
    tick();
    reset_N = 1'b0;
    tick();
    reset_N = 1'b1;
    repeat (20) tick();
    reset_N = 1'b0;
    #1;
    chk("midsweep_busy_A",  {31'd0, ifa.busy},  32'd1);
    chk("midsweep_rdata_A", {16'd0, ifa.rdata}, 32'd0);
    tick();
    reset_N = 1'b1;
    measure_clear("clear3");
    tick();
    for (int i = 0; i < 64; i++) begin
      idle(2);
      put(2, 2, 1'b0, 6'(i), 16'h0000);
      eg(2, 4'b0100);
      er(2, 4'b0100, 16'h0000);
      tick();
    end
`endif

    idle(2);
    put(2, 0, 1'b1, 6'h3F, 16'h5A5A);  eg(2, 4'b0001);
    tick();
    idle(2);
    put(2, 3, 1'b0, 6'h3F, 16'h0000);  eg(2, 4'b1000);  er(2, 4'b1000, 16'h5A5A);
    tick();
    idle(2);
    tick();
    tick();
    @(negedge clock);
    chk("left_gnt_A",  qg_a.size(), 32'd0);
    chk("left_gnt_B",  qg_b.size(), 32'd0);
    chk("left_read_A", qr_a.size(), 32'd0);
    chk("left_read_B", qr_b.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
